// File: rtl/issue_scheduler_if.sv
// Bundle between the issue scheduler and its neighbours (fetcher, decoder,
// ROB, RS, LSB).
//
// Modports:
//   master - the issue scheduler. It drives if_ready_out, dec_code_out,
//            dec_pc_out, all iss_* outputs, illegal_out and busy_out. It reads
//            clear_in, the fetch offer, the decoder fields and the free/tag/
//            jalr_done status inputs.
//   slave  - the surrounding pipeline (or a testbench). The directions are the
//            mirror image of master.
interface issue_scheduler_if #(
    parameter int OPE_W     = 6,
    parameter int REG_W     = 6,
    parameter int ROB_TAG_W = 4
);
    logic                 clear_in;

    logic                 if_valid_in;
    logic [31:0]          if_code_in;
    logic [31:0]          if_pc_in;
    logic                 if_ready_out;

    logic [31:0]          dec_code_out;
    logic [31:0]          dec_pc_out;
    logic [OPE_W-1:0]     dec_type_in;
    logic [REG_W-1:0]     dec_rd_in;
    logic [REG_W-1:0]     dec_rs1_in;
    logic [REG_W-1:0]     dec_rs2_in;
    logic [31:0]          dec_imm_in;

    logic                 rob_free_in;
    logic [ROB_TAG_W-1:0] rob_tag_in;
    logic                 rs_free_in;
    logic                 lsb_free_in;
    logic                 jalr_done_in;

    logic                 iss_rs_out;
    logic                 iss_lsb_out;
    logic [OPE_W-1:0]     iss_type_out;
    logic [REG_W-1:0]     iss_rd_out;
    logic [REG_W-1:0]     iss_rs1_out;
    logic [REG_W-1:0]     iss_rs2_out;
    logic [31:0]          iss_imm_out;
    logic [31:0]          iss_pc_out;
    logic [ROB_TAG_W-1:0] iss_tag_out;
    logic                 illegal_out;
    logic                 busy_out;

    modport master (
        input  clear_in,
        input  if_valid_in, if_code_in, if_pc_in,
        output if_ready_out,
        output dec_code_out, dec_pc_out,
        input  dec_type_in, dec_rd_in, dec_rs1_in, dec_rs2_in, dec_imm_in,
        input  rob_free_in, rob_tag_in, rs_free_in, lsb_free_in, jalr_done_in,
        output iss_rs_out, iss_lsb_out, iss_type_out, iss_rd_out, iss_rs1_out,
        output iss_rs2_out, iss_imm_out, iss_pc_out, iss_tag_out,
        output illegal_out, busy_out
    );

    modport slave (
        output clear_in,
        output if_valid_in, if_code_in, if_pc_in,
        input  if_ready_out,
        input  dec_code_out, dec_pc_out,
        output dec_type_in, dec_rd_in, dec_rs1_in, dec_rs2_in, dec_imm_in,
        output rob_free_in, rob_tag_in, rs_free_in, lsb_free_in, jalr_done_in,
        input  iss_rs_out, iss_lsb_out, iss_type_out, iss_rd_out, iss_rs1_out,
        input  iss_rs2_out, iss_imm_out, iss_pc_out, iss_tag_out,
        input  illegal_out, busy_out
    );
endinterface

// File: rtl/issue_scheduler.sv
// Issue scheduler: a FIFO instruction queue between the fetcher and the
// RS/LSB/ROB. The queue head is shown to an external decoder; the decoded
// fields come back the same cycle and the head is issued in order to the RS or
// the LSB together with the ROB tag offered for it.
//
// Ports:
//   clk_in  - clock, all state updates on the rising edge
//   rst_in  - synchronous reset, active low
//   bus     - issue_scheduler_if.master: fetch offer/ready, decoder head
//             and fields, ROB/RS/LSB status, registered issue outputs,
//             illegal_out drop pulse and busy_out (waiting for a JALR target)
//
// Decoder type codes relied on here: 0 = empty/illegal, 4 = JALR,
// 11..15 = LB, LH, LW, LBU, LHU, 16..18 = SB, SH, SW. Loads and stores go to
// the LSB; every other nonzero type goes to the RS.
module issue_scheduler #(
    parameter int QUEUE_DEPTH = 16,
    parameter int OPE_W       = 6,
    parameter int REG_W       = 6,
    parameter int ROB_TAG_W   = 4
) (
    input logic               clk_in,
    input logic               rst_in,
    issue_scheduler_if.master bus
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [OPE_W-1:0] OPE_NONE = '0;
    localparam logic [OPE_W-1:0] OPE_JALR = OPE_W'(4);
    localparam logic [OPE_W-1:0] OPE_LB   = OPE_W'(11);
    localparam logic [OPE_W-1:0] OPE_SW   = OPE_W'(18);

    typedef enum logic {
        RUN       = 1'b0,
        WAIT_JALR = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] code_q [QUEUE_DEPTH];
    logic [31:0] pc_q   [QUEUE_DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic head_valid;
    logic head_is_mem;
    logic head_is_jalr;
    logic can_look;
    logic target_free;
    logic issue;
    logic drop;
    logic push;
    logic pop;

    logic                 rs_vld_p1;
    logic                 lsb_vld_p1;
    logic                 illegal_p1;
    logic [OPE_W-1:0]     type_p1;
    logic [REG_W-1:0]     rd_p1;
    logic [REG_W-1:0]     rs1_p1;
    logic [REG_W-1:0]     rs2_p1;
    logic [31:0]          imm_p1;
    logic [31:0]          pc_p1;
    logic [ROB_TAG_W-1:0] tag_p1;

    // Ready comes only from the registered count, so it never depends on
    // same-cycle pops.
    assign bus.if_ready_out = (count != CNT_W'(QUEUE_DEPTH));
    assign bus.dec_code_out = code_q[head];
    assign bus.dec_pc_out   = pc_q[head];
    assign bus.busy_out     = (state == WAIT_JALR);

    always_comb begin
        head_valid   = (count != '0);
        head_is_mem  = (bus.dec_type_in >= OPE_LB) && (bus.dec_type_in <= OPE_SW);
        head_is_jalr = (bus.dec_type_in == OPE_JALR);
        can_look     = (state == RUN) && head_valid && !bus.clear_in;
        target_free  = head_is_mem ? bus.lsb_free_in : bus.rs_free_in;
        // A type-0 head is dropped without consuming a tag or a free slot.
        drop         = can_look && (bus.dec_type_in == OPE_NONE);
        issue        = can_look && (bus.dec_type_in != OPE_NONE) &&
                       bus.rob_free_in && target_free;
        push         = bus.if_valid_in && bus.if_ready_out && !bus.clear_in;
        pop          = issue || drop;

        state_next = state;
        if (bus.clear_in) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN:       if (issue && head_is_jalr) state_next = WAIT_JALR;
                WAIT_JALR: if (bus.jalr_done_in)      state_next = RUN;
                default:   state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Queue storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk_in) begin
        if (push) begin
            code_q[tail] <= bus.if_code_in;
            pc_q[tail]   <= bus.if_pc_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in || bus.clear_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue stage: pulses clear on reset or flush; fields change only on issue.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rs_vld_p1  <= 1'b0;
            lsb_vld_p1 <= 1'b0;
            illegal_p1 <= 1'b0;
            type_p1    <= '0;
            rd_p1      <= '0;
            rs1_p1     <= '0;
            rs2_p1     <= '0;
            imm_p1     <= '0;
            pc_p1      <= '0;
            tag_p1     <= '0;
        end else begin
            rs_vld_p1  <= issue && !head_is_mem;
            lsb_vld_p1 <= issue && head_is_mem;
            illegal_p1 <= drop;
            if (issue) begin
                type_p1 <= bus.dec_type_in;
                rd_p1   <= bus.dec_rd_in;
                rs1_p1  <= bus.dec_rs1_in;
                rs2_p1  <= bus.dec_rs2_in;
                imm_p1  <= bus.dec_imm_in;
                pc_p1   <= bus.dec_pc_out;
                tag_p1  <= bus.rob_tag_in;
            end
        end
    end

    assign bus.iss_rs_out   = rs_vld_p1;
    assign bus.iss_lsb_out  = lsb_vld_p1;
    assign bus.illegal_out  = illegal_p1;
    assign bus.iss_type_out = type_p1;
    assign bus.iss_rd_out   = rd_p1;
    assign bus.iss_rs1_out  = rs1_p1;
    assign bus.iss_rs2_out  = rs2_p1;
    assign bus.iss_imm_out  = imm_p1;
    assign bus.iss_pc_out   = pc_p1;
    assign bus.iss_tag_out  = tag_p1;

endmodule
